// File: rtl/csa_resolve_pkg.sv
// Shared defaults and types for the carry-save resolver.
// stage_t is the record view of one pipeline stage at the default widths.
package csa_resolve_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_SEG   = 8;
    localparam int unsigned DEF_TAG_W = 8;
    localparam int unsigned DEF_NSTG  = DEF_WIDTH / DEF_SEG;

    typedef struct packed {
        logic                 valid;
        logic [DEF_TAG_W-1:0] tag;
        logic [DEF_WIDTH-1:0] sum;
        logic                 carry;
        logic [DEF_WIDTH-1:0] vs;
        logic [DEF_WIDTH-1:0] vc;
    } stage_t;

    function automatic int unsigned nstg(input int unsigned width, input int unsigned seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/csa_resolve_stage.sv
// One resolver segment: registered SEG-bit add with carry in/out and hold enable.
module csa_resolve_stage #(
    parameter int unsigned SEG = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    logic [SEG:0] add;

    assign add = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

    always_ff @(posedge clk) begin
        if (reset) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (en) begin
            sum  <= add[SEG-1:0];
            cout <= add[SEG];
        end
    end

endmodule

// File: rtl/csa_resolve.sv
// Skewed ripple resolver: converts a carry-save pair to binary one SEG-bit segment per stage,
// with valid/ready backpressure that freezes the whole pipeline.
module csa_resolve
    import csa_resolve_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SEG   = DEF_SEG,
    parameter int unsigned TAG_W = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_vs,
    input  logic [WIDTH-1:0] in_vc,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned NSTG = nstg(WIDTH, SEG);

    logic             stall;
    logic             en;
    logic [NSTG-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q [NSTG];
    logic [NSTG-1:0]  carry;

    assign stall    = out_valid && !out_ready;
    assign en       = !stall;
    assign in_ready = !stall && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < NSTG; i++) tag_q[i] <= '0;
        end else if (en) begin
            valid_q[0] <= in_valid;
            tag_q[0]   <= in_tag;
            for (int i = 1; i < NSTG; i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    for (genvar k = 0; k < NSTG; k++) begin : gen_stg
        // Bits of vs/vc not yet consumed by this or any earlier stage.
        localparam int unsigned PW = WIDTH - (k + 1) * SEG;

        logic [SEG-1:0]         op_vs;
        logic [SEG-1:0]         op_vc;
        logic                   cin;
        logic [SEG-1:0]         seg_sum;
        logic [(k+1)*SEG-1:0]   full_sum;

        if (k == 0) begin : gen_first
            assign op_vs    = in_vs[SEG-1:0];
            assign op_vc    = in_vc[SEG-1:0];
            assign cin      = 1'b0;
            assign full_sum = seg_sum;
        end else begin : gen_rest
            logic [k*SEG-1:0] low_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    low_q <= '0;
                end else if (en) begin
                    low_q <= gen_stg[k-1].full_sum;
                end
            end

            assign op_vs    = gen_stg[k-1].gen_pend.pvs_q[SEG-1:0];
            assign op_vc    = gen_stg[k-1].gen_pend.pvc_q[SEG-1:0];
            assign cin      = carry[k-1];
            assign full_sum = {seg_sum, low_q};
        end

        if (PW > 0) begin : gen_pend
            logic [PW-1:0] pvs_q;
            logic [PW-1:0] pvc_q;

            if (k == 0) begin : gen_src_in
                always_ff @(posedge clk) begin
                    if (en) begin
                        pvs_q <= in_vs[WIDTH-1:SEG];
                        pvc_q <= in_vc[WIDTH-1:SEG];
                    end
                end
            end else begin : gen_src_prev
                always_ff @(posedge clk) begin
                    if (en) begin
                        pvs_q <= gen_stg[k-1].gen_pend.pvs_q[PW+SEG-1:SEG];
                        pvc_q <= gen_stg[k-1].gen_pend.pvc_q[PW+SEG-1:SEG];
                    end
                end
            end
        end

        csa_resolve_stage #(
            .SEG (SEG)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .a     (op_vs),
            .b     (op_vc),
            .cin   (cin),
            .sum   (seg_sum),
            .cout  (carry[k])
        );
    end

    assign out_sum   = gen_stg[NSTG-1].full_sum;
    assign out_cout  = carry[NSTG-1];
    assign out_tag   = tag_q[NSTG-1];
    assign out_valid = valid_q[NSTG-1];

endmodule

// File: tb/tb_csa_resolve.sv
// Self-checking bench for csa_resolve: directed known answers, random streams against
// an arithmetic scoreboard, backpressure, mid-stream reset and the single-stage variant.
module tb_csa_resolve;

    localparam int W    = 32;
    localparam int TW   = 8;
    localparam int LAT  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  in_vs, in_vc;
    logic [TW-1:0] in_tag;
    logic          in_valid, in_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic [TW-1:0] out_tag;
    logic          out_valid, out_ready;

    logic [W-1:0]  v1_in_vs, v1_in_vc;
    logic [TW-1:0] v1_in_tag;
    logic          v1_in_valid, v1_in_ready;
    logic [W-1:0]  v1_out_sum;
    logic          v1_out_cout;
    logic [TW-1:0] v1_out_tag;
    logic          v1_out_valid, v1_out_ready;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]  vs_arr  [16];
    logic [W-1:0]  vc_arr  [16];
    logic [TW-1:0] tag_arr [16];
    logic [W-1:0]  kat_sum [16];
    logic          kat_cout[16];
    logic [TW+W:0] exp_q [$];

    always #5 clk = ~clk;

    csa_resolve #(.WIDTH(32), .SEG(8), .TAG_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_vs     (in_vs),
        .in_vc     (in_vc),
        .in_tag    (in_tag),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_tag   (out_tag),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    csa_resolve #(.WIDTH(32), .SEG(32), .TAG_W(8)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_vs     (v1_in_vs),
        .in_vc     (v1_in_vc),
        .in_tag    (v1_in_tag),
        .in_valid  (v1_in_valid),
        .in_ready  (v1_in_ready),
        .out_sum   (v1_out_sum),
        .out_cout  (v1_out_cout),
        .out_tag   (v1_out_tag),
        .out_valid (v1_out_valid),
        .out_ready (v1_out_ready)
    );

    function automatic logic [TW+W:0] model(input logic [TW-1:0] tag, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return {tag, s};
    endfunction

    // Streams n pairs from the stimulus arrays; out_ready drops for stall_len cycles at stall_at.
    task automatic run_stream(input string name, input int n, input int stall_at,
                              input int stall_len, input bit b2b, input bit kat);
        int sent = 0;
        int got = 0;
        int first = -1;
        int extra = 0;
        bit prev_stall = 1'b0;
        logic [TW+W:0] prev_out = '0;
        logic [TW+W:0] exp;
        exp_q.delete();
        for (int cyc = 0; cyc < n + stall_len + 20 && got < n; cyc++) begin
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (sent < n) begin
                in_valid = 1'b1;
                in_vs    = vs_arr[sent];
                in_vc    = vc_arr[sent];
                in_tag   = tag_arr[sent];
            end else begin
                in_valid = 1'b0;
                in_vs    = $urandom;
                in_vc    = $urandom;
                in_tag   = TW'($urandom);
            end
            #1;
            if (prev_stall) begin
                checks++;
                if ({out_tag, out_cout, out_sum} !== prev_out) begin
                    failures++;
                    $display("FAIL %s_stall_hold cyc=%0d got=%h want=%h", name, cyc,
                             {out_tag, out_cout, out_sum}, prev_out);
                end
            end
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_stall_in_ready cyc=%0d got=%b want=0", name, cyc, in_ready);
                end
            end
            if (b2b) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_b2b_in_ready cyc=%0d got=%b want=1", name, cyc, in_ready);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_tag, in_vs, in_vc));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (first < 0) first = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s_spurious cyc=%0d got=%h want=none", name, cyc,
                             {out_tag, out_cout, out_sum});
                end else begin
                    exp = exp_q.pop_front();
                    if ({out_tag, out_cout, out_sum} !== exp) begin
                        failures++;
                        $display("FAIL %s_result idx=%0d got=%h want=%h", name, got,
                                 {out_tag, out_cout, out_sum}, exp);
                    end
                end
                if (kat) begin
                    checks++;
                    if ({out_cout, out_sum} !== {kat_cout[got], kat_sum[got]}) begin
                        failures++;
                        $display("FAIL %s_known idx=%0d got=%h want=%h", name, got,
                                 {out_cout, out_sum}, {kat_cout[got], kat_sum[got]});
                    end
                end
                if (b2b) begin
                    checks++;
                    if (cyc != first + got) begin
                        failures++;
                        $display("FAIL %s_consecutive idx=%0d got_cyc=%0d want_cyc=%0d", name,
                                 got, cyc, first + got);
                    end
                end
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_tag, out_cout, out_sum};
            @(posedge clk);
            #1;
        end
        checks++;
        if (got != n) begin
            failures++;
            $display("FAIL %s_count got=%0d want=%0d", name, got, n);
        end
        checks++;
        if (first != LAT) begin
            failures++;
            $display("FAIL %s_latency got=%0d want=%0d", name, first, LAT);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (out_valid) extra++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL %s_duplicate got=%0d want=0", name, extra);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_vs     = '1;
        in_vc     = '1;
        in_tag    = 8'hFF;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_sum, out_cout, out_tag, in_ready} !== '0) begin
            failures++;
            $display("FAIL reset_state got=%b%h%b%h%b want=0", out_valid, out_sum, out_cout,
                     out_tag, in_ready);
        end
        checks++;
        if ({v1_out_valid, v1_out_sum, v1_out_cout, v1_out_tag} !== '0) begin
            failures++;
            $display("FAIL reset_state_nstg1 got=%b%h%b%h want=0", v1_out_valid, v1_out_sum,
                     v1_out_cout, v1_out_tag);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_in_ready got=%b want=1", in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        vs_arr[0]   = 32'h12345678;
        vc_arr[0]   = 32'h11111110;
        tag_arr[0]  = 8'h5A;
        kat_sum[0]  = 32'h23456788;
        kat_cout[0] = 1'b0;
        run_stream("single", 1, 100, 0, 1'b0, 1'b1);
    endtask

    task automatic test_carry();
        vs_arr[0] = 32'hFFFFFFFF; vc_arr[0] = 32'h00000001; kat_sum[0] = 32'h0;   kat_cout[0] = 1;
        vs_arr[1] = 32'h80000000; vc_arr[1] = 32'h80000000; kat_sum[1] = 32'h0;   kat_cout[1] = 1;
        vs_arr[2] = 32'h000000FF; vc_arr[2] = 32'h00000001; kat_sum[2] = 32'h100; kat_cout[2] = 0;
        vs_arr[3] = 32'h00FFFFFF; vc_arr[3] = 32'h00000001; kat_sum[3] = 32'h01000000;
        kat_cout[3] = 0;
        for (int i = 0; i < 4; i++) tag_arr[i] = TW'(8'hC0 + i);
        run_stream("carry", 4, 100, 0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            vs_arr[i]  = $urandom;
            vc_arr[i]  = $urandom;
            tag_arr[i] = TW'(i);
        end
        run_stream("b2b", 16, 100, 0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) begin
            vs_arr[i]  = $urandom;
            vc_arr[i]  = $urandom;
            tag_arr[i] = TW'(8'h80 + i);
        end
        run_stream("bp", 8, 6, 5, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int at = -1;
        logic [W-1:0] sum_at = '0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_vs    = $urandom;
            in_vc    = $urandom;
            in_tag   = TW'(8'h30 + i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_in_ready got=%b want=0", in_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_sum, out_cout, out_tag} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got=%b%h%b%h want=0", out_valid, out_sum, out_cout,
                     out_tag);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_release got=%b want=1", in_ready);
        end
        in_valid = 1'b1;
        in_vs    = 32'd1;
        in_vc    = 32'd2;
        in_tag   = 8'h77;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc == 1) begin
                in_valid = 1'b0;
                in_vs    = $urandom;
            end
            #1;
            if (out_valid) begin
                seen++;
                if (at < 0) begin
                    at     = cyc;
                    sum_at = out_sum;
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen != 1 || at != LAT || sum_at !== 32'd3) begin
            failures++;
            $display("FAIL midreset_new_pair got=count%0d/cyc%0d/sum%0h want=count1/cyc%0d/sum3",
                     seen, at, sum_at, LAT);
        end
    endtask

    task automatic test_nstg1();
        int at = -1;
        int seen = 0;
        logic [W:0] res = '0;
        v1_in_valid = 1'b1;
        v1_in_vs    = 32'hFFFFFFFF;
        v1_in_vc    = 32'hFFFFFFFF;
        v1_in_tag   = 8'h11;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc == 1) v1_in_valid = 1'b0;
            #1;
            if (v1_out_valid) begin
                seen++;
                if (at < 0) begin
                    at  = cyc;
                    res = {v1_out_cout, v1_out_sum};
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen != 1 || at != 1 || res !== {1'b1, 32'hFFFFFFFE}) begin
            failures++;
            $display("FAIL nstg1 got=count%0d/cyc%0d/%h want=count1/cyc1/1fffffffe", seen, at, res);
        end
    endtask

    initial begin
        in_valid     = 1'b0;
        in_vs        = '0;
        in_vc        = '0;
        in_tag       = '0;
        out_ready    = 1'b1;
        v1_in_valid  = 1'b0;
        v1_in_vs     = '0;
        v1_in_vc     = '0;
        v1_in_tag    = '0;
        v1_out_ready = 1'b1;
        reset        = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_carry();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_nstg1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
